// File: rtl/led_row_shifter_if.sv
// Sequencer / frame-buffer / panel-pin bundle for led_row_shifter.
// test_mode exists only when LED_SHIFTER_TEST_PATTERN_EN is defined.
interface led_row_shifter_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int COL_BITS        = 6,
  parameter int ROW_BITS        = 4,
  parameter int SCAN_VAL_LENGTH = 5
);
  logic                         latch_pts;
  logic                         sr_enable;
  logic [SCAN_VAL_LENGTH-1:0]   scan_val;
  logic [DATA_WIDTH-1:0]        current_bcm_bit;
  logic                         shift_reg_empty;
  logic [ROW_BITS+COL_BITS-1:0] fb_addr;
  logic                         fb_rd_en;
  logic [6*DATA_WIDTH-1:0]      fb_rdata;
  logic                         r0, g0, b0, r1, g1, b1;
`ifdef LED_SHIFTER_TEST_PATTERN_EN
  logic                         test_mode;

  modport master (
    output latch_pts, sr_enable, scan_val, current_bcm_bit, fb_rdata, test_mode,
    input  shift_reg_empty, fb_addr, fb_rd_en, r0, g0, b0, r1, g1, b1
  );
  modport slave (
    input  latch_pts, sr_enable, scan_val, current_bcm_bit, fb_rdata, test_mode,
    output shift_reg_empty, fb_addr, fb_rd_en, r0, g0, b0, r1, g1, b1
  );
`else
  modport master (
    output latch_pts, sr_enable, scan_val, current_bcm_bit, fb_rdata,
    input  shift_reg_empty, fb_addr, fb_rd_en, r0, g0, b0, r1, g1, b1
  );
  modport slave (
    input  latch_pts, sr_enable, scan_val, current_bcm_bit, fb_rdata,
    output shift_reg_empty, fb_addr, fb_rd_en, r0, g0, b0, r1, g1, b1
  );
`endif
endinterface

// File: rtl/led_row_shifter.sv
// LED matrix row serializer: streams one column pair per cycle from a 1-cycle-latency frame buffer.
// Optional LED_SHIFTER_TEST_PATTERN_EN adds test_mode, replacing RAM data with a generated pattern.
module led_row_shifter #(
  parameter int MATRIX_WIDTH    = 64,
  parameter int MATRIX_HEIGHT   = 32,
  parameter int DATA_WIDTH      = 8,
  parameter int COL_BITS        = 6,
  parameter int ROW_BITS        = 4,
  parameter int SCAN_VAL_LENGTH = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  led_row_shifter_if.slave bus
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(MATRIX_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [COL_BITS-1:0]     col_cnt, col_nxt;
  logic [ROW_BITS-1:0]     row_q;
  logic [DATA_WIDTH-1:0]   bit_q;

  logic                    latch_go;
  logic                    col_last;
  logic                    tp_on;
  logic                    rd_raw;
  logic [ROW_BITS-1:0]     row_in;
  logic [ROW_BITS-1:0]     addr_row;
  logic [COL_BITS-1:0]     addr_col;
  logic [6*DATA_WIDTH-1:0] pix;

  // Selected BCM bit of one channel; an index past the channel width yields 0.
  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] chan,
                                    input logic [DATA_WIDTH-1:0] idx);
    return |(chan & (DATA_WIDTH'(1) << idx));
  endfunction

  // Row pair wraps within the top half; for a power-of-two height this is the low ROW_BITS.
  assign row_in   = ROW_BITS'(bus.scan_val % SCAN_VAL_LENGTH'(MATRIX_HEIGHT / 2));
  assign latch_go = bus.latch_pts & n_rst;
  assign col_last = (state == SHIFT) && (col_cnt == LAST_COL);

`ifdef LED_SHIFTER_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] pat_r, pat_g0, pat_g1, pat_b;

  assign tp_on  = bus.test_mode;
  assign pat_r  = DATA_WIDTH'(int'(col_cnt) * 4);
  assign pat_g0 = DATA_WIDTH'(int'(row_q) * 16);
  assign pat_g1 = DATA_WIDTH'((int'(row_q) + 8) * 16);
  assign pat_b  = DATA_WIDTH'(8'hFF);
  assign pix    = tp_on ? {pat_b, pat_g1, pat_r, pat_b, pat_g0, pat_r} : bus.fb_rdata;
`else
  assign tp_on  = 1'b0;
  assign pix    = bus.fb_rdata;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_q   <= '0;
      bit_q   <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      if (latch_go) begin
        row_q <= row_in;
        bit_q <= bus.current_bcm_bit;
      end
    end
  end

  // A stall re-reads the current column so fb_rdata stays valid for it next cycle.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    addr_row  = row_q;
    addr_col  = col_cnt;
    rd_raw    = 1'b0;
    if (latch_go) begin
      state_nxt = SHIFT;
      col_nxt   = '0;
      addr_row  = row_in;
      addr_col  = '0;
      rd_raw    = 1'b1;
    end else if (state == SHIFT) begin
      rd_raw = 1'b1;
      if (bus.sr_enable) begin
        col_nxt = col_cnt + 1'b1;
        if (col_last) begin
          state_nxt = IDLE;
          rd_raw    = 1'b0;
        end else begin
          addr_col = col_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.fb_addr         = {addr_row, addr_col};
    bus.fb_rd_en        = rd_raw & ~tp_on;
    bus.shift_reg_empty = (state == IDLE) || (col_last && bus.sr_enable);
    bus.r0 = 1'b0;
    bus.g0 = 1'b0;
    bus.b0 = 1'b0;
    bus.r1 = 1'b0;
    bus.g1 = 1'b0;
    bus.b1 = 1'b0;
    if (state == SHIFT) begin
      bus.r0 = pick_bit(pix[0*DATA_WIDTH +: DATA_WIDTH], bit_q);
      bus.g0 = pick_bit(pix[1*DATA_WIDTH +: DATA_WIDTH], bit_q);
      bus.b0 = pick_bit(pix[2*DATA_WIDTH +: DATA_WIDTH], bit_q);
      bus.r1 = pick_bit(pix[3*DATA_WIDTH +: DATA_WIDTH], bit_q);
      bus.g1 = pick_bit(pix[4*DATA_WIDTH +: DATA_WIDTH], bit_q);
      bus.b1 = pick_bit(pix[5*DATA_WIDTH +: DATA_WIDTH], bit_q);
    end
  end

endmodule

// File: tb/tb_led_row_shifter.sv
// Directed bench for led_row_shifter: vector table plus full-line, stall, restart and reset sequences.
module tb_led_row_shifter;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  bit   mem_mode;

  led_row_shifter_if #(.DATA_WIDTH(8), .COL_BITS(6), .ROW_BITS(4), .SCAN_VAL_LENGTH(5)) bus ();

  led_row_shifter #(
    .MATRIX_WIDTH(64), .MATRIX_HEIGHT(32), .DATA_WIDTH(8),
    .COL_BITS(6), .ROW_BITS(4), .SCAN_VAL_LENGTH(5)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer contents, packed {B1,G1,R1,B0,G0,R0}.
  function automatic logic [47:0] mem_data(input logic [9:0] a);
    int c;
    int r;
    c = int'(a[5:0]);
    r = int'(a[9:6]);
    if (mem_mode) return {8'h00, 8'hFF, 8'h7F, 8'h40, 8'h01, 8'h80};
    return {8'(c * 3), 8'hA5, 8'(c + r), 8'(r * 16), 8'(255 - c), 8'(c)};
  endfunction

  // Generated test-pattern pixel data for a given row pair and column.
  function automatic logic [47:0] pat_data(input int r, input int c);
    return {8'hFF, 8'((r + 8) * 16), 8'(c * 4), 8'hFF, 8'(r * 16), 8'(c * 4)};
  endfunction

  function automatic logic [5:0] exp_rgb(input logic [47:0] d, input logic [7:0] bcm);
    logic [5:0] v;
    v = '0;
    for (int ch = 0; ch < 6; ch++)
      v[ch] = (bcm < 8) ? d[ch*8 + int'(bcm)] : 1'b0;
    return v;
  endfunction

  always @(posedge clk)
    if (bus.fb_rd_en) bus.fb_rdata <= mem_data(bus.fb_addr);

  function automatic logic [5:0] act_rgb();
    return {bus.b1, bus.g1, bus.r1, bus.b0, bus.g0, bus.r0};
  endfunction

  task automatic check(input string name, input int col, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s col=%0d got=%h expected=%h", name, col, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic e, input logic [4:0] s, input logic [7:0] b);
    @(negedge clk);
    bus.latch_pts       = l;
    bus.sr_enable       = e;
    bus.scan_val        = s;
    bus.current_bcm_bit = b;
    #1;
  endtask

  task automatic idle_chk(input string name);
    drive(1'b0, 1'b1, 5'd0, 8'd0);
    check({name, "_empty"}, -1, 16'(bus.shift_reg_empty), 16'd1);
    check({name, "_rd_en"}, -1, 16'(bus.fb_rd_en), 16'd0);
    check({name, "_rgb"},   -1, 16'(act_rgb()), 16'd0);
  endtask

  // latch_pts then ncols enabled columns, with an optional stall of stall_len cycles at stall_at.
  task automatic line(input logic [4:0] scan, input logic [7:0] bcm, input int ncols,
                      input int stall_at, input int stall_len, input bit tp);
    logic [3:0] row;
    int         c;
    int         stalls;
    bit         stalled;
    logic [9:0] a_exp;
    row    = scan[3:0];
    stalls = stall_len;
    drive(1'b1, 1'b0, scan, bcm);
    check("latch_addr",  0, 16'(bus.fb_addr), 16'({row, 6'd0}));
    check("latch_rd_en", 0, 16'(bus.fb_rd_en), tp ? 16'd0 : 16'd1);
    c = 0;
    while (c < ncols) begin
      stalled = (c == stall_at) && (stalls > 0);
      drive(1'b0, !stalled, scan, bcm);
      if (stalled)     a_exp = {row, 6'(c)};
      else if (c < 63) a_exp = {row, 6'(c + 1)};
      else             a_exp = {row, 6'd63};
      check("addr",  c, 16'(bus.fb_addr), 16'(a_exp));
      check("rd_en", c, 16'(bus.fb_rd_en), 16'((!tp) && (stalled || c < 63)));
      check("empty", c, 16'(bus.shift_reg_empty), 16'(!stalled && c == 63));
      check("rgb",   c, 16'(act_rgb()),
            16'(tp ? exp_rgb(pat_data(int'(row), c), bcm) : exp_rgb(mem_data({row, 6'(c)}), bcm)));
      if (stalled) stalls--;
      else         c++;
    end
  endtask

  typedef struct {
    logic       latch;
    logic       en;
    logic [4:0] scan;
    logic [7:0] bcm;
    logic       empty;
    logic       rd;
    logic [9:0] addr;
    logic [5:0] rgb;
    logic       rgb_dc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    checks   = 0;
    failures = 0;
    mem_mode = 1'b1;
    n_rst    = 1'b0;
    bus.latch_pts       = 1'b0;
    bus.sr_enable       = 1'b0;
    bus.scan_val        = '0;
    bus.current_bcm_bit = '0;
`ifdef LED_SHIFTER_TEST_PATTERN_EN
    bus.test_mode = 1'b0;
`endif

    // Constant RAM word here: R0=80 G0=01 B0=40 R1=7F G1=FF B1=00; rgb = {b1,g1,r1,b0,g0,r0}.
    tbl[0]  = '{1'b0, 1'b0, 5'd0,  8'd0, 1'b1, 1'b0, 10'h000, 6'b000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'd0,  8'd0, 1'b1, 1'b0, 10'h000, 6'b000000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5'd7,  8'd7, 1'b1, 1'b1, 10'h1C0, 6'b000000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'd7,  8'd7, 1'b0, 1'b1, 10'h1C1, 6'b010001, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'd7,  8'd7, 1'b0, 1'b1, 10'h1C2, 6'b010001, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd7,  8'd7, 1'b0, 1'b1, 10'h1C2, 6'b010001, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 5'd5,  8'd6, 1'b0, 1'b1, 10'h140, 6'b000000, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 5'd5,  8'd6, 1'b0, 1'b1, 10'h141, 6'b011100, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 5'h13, 8'd9, 1'b0, 1'b1, 10'h0C0, 6'b000000, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 5'h13, 8'd9, 1'b0, 1'b1, 10'h0C1, 6'b000000, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'h13, 8'd9, 1'b0, 1'b1, 10'h0C2, 6'b000000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 5'd1,  8'd0, 1'b0, 1'b1, 10'h040, 6'b000000, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 5'd1,  8'd0, 1'b0, 1'b1, 10'h041, 6'b011010, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("rst_empty", -1, 16'(bus.shift_reg_empty), 16'd1);
    check("rst_rd_en", -1, 16'(bus.fb_rd_en), 16'd0);
    check("rst_addr",  -1, 16'(bus.fb_addr), 16'd0);
    check("rst_rgb",   -1, 16'(act_rgb()), 16'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].latch, tbl[i].en, tbl[i].scan, tbl[i].bcm);
      check("vec_empty", i, 16'(bus.shift_reg_empty), 16'(tbl[i].empty));
      check("vec_rd_en", i, 16'(bus.fb_rd_en), 16'(tbl[i].rd));
      check("vec_addr",  i, 16'(bus.fb_addr), 16'(tbl[i].addr));
      if (!tbl[i].rgb_dc) check("vec_rgb", i, 16'(act_rgb()), 16'(tbl[i].rgb));
    end

    mem_mode = 1'b0;
    line(5'd3, 8'd0, 64, -1, 0, 1'b0);
    idle_chk("basic_idle");

    line(5'd2, 8'd1, 64, 10, 3, 1'b0);
    idle_chk("stall_idle");

    line(5'd4, 8'd0, 30, -1, 0, 1'b0);
    line(5'd5, 8'd3, 64, -1, 0, 1'b0);
    idle_chk("restart_idle");

    line(5'd6, 8'd0, 20, -1, 0, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst_empty", 20, 16'(bus.shift_reg_empty), 16'd1);
    check("midrst_rd_en", 20, 16'(bus.fb_rd_en), 16'd0);
    check("midrst_rgb",   20, 16'(act_rgb()), 16'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) idle_chk("post_rst");
    line(5'd6, 8'd2, 64, -1, 0, 1'b0);
    idle_chk("post_rst_line");

`ifdef LED_SHIFTER_TEST_PATTERN_EN
    bus.test_mode = 1'b1;
    line(5'd2, 8'd2, 64, -1, 0, 1'b1);
    idle_chk("tp_idle");
    bus.test_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
